// File: rtl/snn_lif_layer.sv
// -----------------------------------------------------------------------------
// snn_lif_layer
//
// Fully connected layer of leaky integrate-and-fire neurons. Every neuron j
// sees all N_IN input spike lines through its own row of signed weights
// w[j*N_IN + i]. One timestep is evaluated per step_en pulse: the membrane
// leaks by v >> LEAK_SHIFT, the weighted input spikes are added, the result
// is clamped to the unsigned membrane range and compared to THRESH. A neuron
// that fires resets to 0 and sits out REFRAC timesteps, ignoring its inputs.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset (weights, membranes, counters)
//   in_spk     [N_IN]   input spikes, sampled when step_en=1
//   step_en    advance every neuron by one timestep this cycle
//   cfg_we     weight write strobe
//   cfg_addr   [AW]     weight index = out_idx*N_IN + in_idx
//   cfg_data   [W_W]    signed weight value
//   mon_sel    [MW]     neuron whose membrane is shown on v_mon
//   out_spk    [N_OUT]  registered spike pulses, one cycle after step_en
//   v_mon      [V_W]    membrane of neuron mon_sel (0 if out of range)
//   step_done  registered pulse one cycle after every step_en
// -----------------------------------------------------------------------------

// Weight register file: one W_W-bit register per synapse, written through a
// per-entry address decode so indices >= NW simply never match.
//   clk, rst_n   clock and synchronous active-low reset (clears to 0)
//   we, addr, data  write port
//   w_flat       all weights, entry k at bits [k*W_W +: W_W]
module snn_lif_wregs #(
    parameter int NW  = 6,
    parameter int W_W = 4,
    parameter int AW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [W_W-1:0]    data,
    output logic [NW*W_W-1:0] w_flat
);

    logic [W_W-1:0] w [NW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) begin
                w[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (we && (addr == AW'(k))) begin
                    w[k] <= data;
                end
            end
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_flat
        assign w_flat[g*W_W +: W_W] = w[g];
    end

endmodule

module snn_lif_layer #(
    parameter int N_IN       = 3,
    parameter int N_OUT      = 2,
    parameter int W_W        = 4,
    parameter int V_W        = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int THRESH     = 20,
    parameter int REFRAC     = 2,
    localparam int AW = ((N_IN * N_OUT) > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int MW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in_spk,
    input  logic             step_en,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [W_W-1:0]   cfg_data,
    input  logic [MW-1:0]    mon_sel,
    output logic [N_OUT-1:0] out_spk,
    output logic [V_W-1:0]   v_mon,
    output logic             step_done
);

    localparam int NW  = N_IN * N_OUT;
    // Synaptic sum is wide enough that N_IN weights of either sign cannot wrap.
    localparam int SW  = W_W + $clog2(N_IN) + 1;
    // Membrane update width: V_W+2 normally; widened only if the synaptic sum
    // itself would not fit with a sign bit to spare.
    localparam int RW  = ((V_W + 2) > (SW + 1)) ? (V_W + 2) : (SW + 1);
    localparam int RFW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic [V_W-1:0] THRESH_V = V_W'(THRESH);
    localparam logic [RFW-1:0] REFRAC_V = RFW'(REFRAC);

    logic [NW*W_W-1:0]     w_flat;
    logic [V_W-1:0]        v       [N_OUT];
    logic [RFW-1:0]        refrac  [N_OUT];
    logic                  refrac_tc [N_OUT];
    logic signed [SW-1:0]  syn     [N_OUT];
    logic [V_W-1:0]        leaked  [N_OUT];
    logic signed [RW-1:0]  raw     [N_OUT];
    logic [V_W-1:0]        v_new   [N_OUT];
    logic [N_OUT-1:0]      fire;

    // Weights are registers, so a write landing on the same edge as a step
    // is only visible to the following step.
    snn_lif_wregs #(
        .NW  (NW),
        .W_W (W_W),
        .AW  (AW)
    ) u_wregs (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we),
        .addr   (cfg_addr),
        .data   (cfg_data),
        .w_flat (w_flat)
    );

    always_comb begin
        logic signed [SW-1:0] acc;
        logic [W_W-1:0]       wv;
        acc  = '0;
        wv   = '0;
        fire = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc = '0;
            for (int i = 0; i < N_IN; i++) begin
                wv = w_flat[(j*N_IN + i)*W_W +: W_W];
                if (in_spk[i]) begin
                    acc = acc + $signed({{(SW-W_W){wv[W_W-1]}}, wv});
                end
            end
            syn[j] = acc;

            leaked[j] = v[j] - (v[j] >> LEAK_SHIFT);
            raw[j]    = $signed({{(RW-V_W){1'b0}}, leaked[j]})
                      + $signed({{(RW-SW){syn[j][SW-1]}}, syn[j]});

            // Clamp to [0, 2^V_W-1]: sign bit means negative, any bit above
            // the membrane width means overflow.
            if (raw[j][RW-1]) begin
                v_new[j] = '0;
            end else if (|raw[j][RW-2:V_W]) begin
                v_new[j] = '1;
            end else begin
                v_new[j] = raw[j][V_W-1:0];
            end

            fire[j]      = (v_new[j] >= THRESH_V);
            refrac_tc[j] = (refrac[j] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                v[j]      <= '0;
                refrac[j] <= '0;
            end
            out_spk   <= '0;
            step_done <= 1'b0;
        end else begin
            out_spk   <= '0;
            step_done <= step_en;
            if (step_en) begin
                for (int j = 0; j < N_OUT; j++) begin
                    if (!refrac_tc[j]) begin
                        // Refractory: count down, membrane pinned at rest.
                        refrac[j] <= refrac[j] - RFW'(1);
                        v[j]      <= '0;
                    end else if (fire[j]) begin
                        out_spk[j] <= 1'b1;
                        v[j]       <= '0;
                        refrac[j]  <= REFRAC_V;
                    end else begin
                        v[j] <= v_new[j];
                    end
                end
            end
        end
    end

    // Decode-style mux so an out-of-range mon_sel matches nothing and reads 0.
    always_comb begin
        v_mon = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (mon_sel == MW'(j)) begin
                v_mon = v[j];
            end
        end
    end

endmodule

// File: tb/tb_snn_lif_layer.sv
module tb_snn_lif_layer;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int W_W   = 4;
    localparam int V_W   = 8;
    localparam int AW    = 3;
    localparam int MW    = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IN-1:0]  in_spk;
    logic             step_en;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [W_W-1:0]   cfg_data;
    logic [MW-1:0]    mon_sel;
    logic [N_OUT-1:0] out_spk;
    logic [V_W-1:0]   v_mon;
    logic             step_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    snn_lif_layer #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .W_W        (W_W),
        .V_W        (V_W),
        .LEAK_SHIFT (2),
        .THRESH     (20),
        .REFRAC     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_spk    (in_spk),
        .step_en   (step_en),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .mon_sel   (mon_sel),
        .out_spk   (out_spk),
        .v_mon     (v_mon),
        .step_done (step_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_step(input logic [N_IN-1:0] s);
        in_spk  = s;
        step_en = 1'b1;
        @(posedge clk);
        #1;
        step_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input logic [AW-1:0] a, input logic [W_W-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_spk  = 3'($urandom);
            step_en = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b1;
        step_en = 1'b0;
        in_spk  = '0;
    endtask

    task automatic read_v(input logic [MW-1:0] sel, output logic [V_W-1:0] v);
        mon_sel = sel;
        #1;
        v = v_mon;
    endtask

    logic [V_W-1:0] vv;
    int exp_v [7] = '{7, 13, 17, 0, 0, 0, 7};
    logic [6:0] exp_f = 7'b0001000;

    initial begin
        rst_n    = 1'b0;
        in_spk   = '0;
        step_en  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        mon_sel  = '0;

        // Reset with random activity on the inputs
        do_reset(3);
        check_val("rst_out_spk", out_spk, 0);
        check_val("rst_step_done", step_done, 0);
        read_v(0, vv); check_val("rst_v0", vv, 0);
        read_v(1, vv); check_val("rst_v1", vv, 0);
        mon_sel = 0;
        for (int k = 0; k < 2; k++) begin
            do_step(3'b111);
            check_val("zero_w_out", out_spk, 0);
            check_val("zero_w_v0", v_mon, 0);
            check_val("zero_w_done", step_done, 1);
        end
        idle_cycle();
        check_val("done_drop", step_done, 0);

        // Integrate and fire, then refractory
        wr_w(0, 4'd7);
        mon_sel = 0;
        for (int k = 0; k < 7; k++) begin
            do_step(3'b001);
            check_val($sformatf("if_v_%0d", k), v_mon, exp_v[k]);
            check_val($sformatf("if_spk_%0d", k), out_spk, {1'b0, exp_f[k]});
            check_val($sformatf("if_done_%0d", k), step_done, 1);
        end
        // No step: state holds, no pulses
        in_spk = 3'b001;
        idle_cycle();
        check_val("hold_v", v_mon, 7);
        check_val("hold_spk", out_spk, 0);
        check_val("hold_done", step_done, 0);

        // Leak only
        do_reset(1);
        wr_w(0, 4'd7);
        mon_sel = 0;
        do_step(3'b001);
        check_val("leak_v0", v_mon, 7);
        do_step(3'b000); check_val("leak_v1", v_mon, 6);
        do_step(3'b000); check_val("leak_v2", v_mon, 5);
        do_step(3'b000); check_val("leak_v3", v_mon, 4);

        // Write and step on the same edge
        do_reset(1);
        wr_w(0, 4'd3);
        cfg_we   = 1'b1;
        cfg_addr = 0;
        cfg_data = 4'd7;
        in_spk   = 3'b001;
        step_en  = 1'b1;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        step_en = 1'b0;
        check_val("coll_v_old_w", v_mon, 3);
        do_step(3'b001);
        check_val("coll_v_new_w", v_mon, 10);

        // Negative weight clamps; neighbour unaffected
        do_reset(1);
        wr_w(4, 4'b1000);
        for (int k = 0; k < 5; k++) begin
            do_step(3'b010);
            check_val($sformatf("neg_spk_%0d", k), out_spk, 0);
            read_v(1, vv); check_val($sformatf("neg_v1_%0d", k), vv, 0);
            read_v(0, vv); check_val($sformatf("neg_v0_%0d", k), vv, 0);
        end
        // Out-of-range addresses do nothing
        wr_w(6, 4'd7);
        wr_w(7, 4'd7);
        do_step(3'b111);
        read_v(0, vv); check_val("oor_v0", vv, 0);
        read_v(1, vv); check_val("oor_v1", vv, 0);

        // Mid-operation reset
        do_reset(1);
        wr_w(0, 4'd7);
        wr_w(3, 4'd7);
        wr_w(4, 4'd7);
        do_step(3'b011);
        read_v(0, vv); check_val("mid_s1_v0", vv, 7);
        read_v(1, vv); check_val("mid_s1_v1", vv, 14);
        do_step(3'b011);
        check_val("mid_s2_spk", out_spk, 2'b10);
        read_v(0, vv); check_val("mid_s2_v0", vv, 13);
        do_step(3'b011);
        check_val("mid_s3_spk", out_spk, 0);
        read_v(0, vv); check_val("mid_s3_v0", vv, 17);
        read_v(1, vv); check_val("mid_s3_v1", vv, 0);
        rst_n   = 1'b0;
        in_spk  = 3'b111;
        step_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        step_en = 1'b0;
        check_val("mid_rst_spk", out_spk, 0);
        check_val("mid_rst_done", step_done, 0);
        read_v(0, vv); check_val("mid_rst_v0", vv, 0);
        read_v(1, vv); check_val("mid_rst_v1", vv, 0);
        for (int k = 0; k < 3; k++) begin
            do_step(3'b111);
            check_val($sformatf("post_spk_%0d", k), out_spk, 0);
            read_v(0, vv); check_val($sformatf("post_v0_%0d", k), vv, 0);
            read_v(1, vv); check_val($sformatf("post_v1_%0d", k), vv, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
